// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP header definitions: format decode, DW0 layout and a header view.
// Used by axis_to_pcie_converter (optional macro AXIS_TO_PCIE_LEN_CHECK_EN lives there).
package pcie_tlp_pkg;

    typedef enum logic [2:0] {
        TLP_3DW_ND = 3'b000,
        TLP_4DW_ND = 3'b001,
        TLP_3DW_WD = 3'b010,
        TLP_4DW_WD = 3'b011
    } tlp_fmt_e;

    typedef struct packed {
        logic [2:0] fmt;
        logic [4:0] typ;
        logic       t9;
        logic [2:0] tc;
        logic       t8;
        logic       attr2;
        logic       ln;
        logic       th;
        logic       td;
        logic       ep;
        logic [1:0] attr;
        logic [1:0] at;
        logic [9:0] length;
    } tlp_dw0_t;

    // dw[3] is DW0 (msb end), dw[0] is DW3
    typedef union packed {
        logic [127:0]     raw;
        logic [3:0][31:0] dw;
    } tlp_hdr_union_t;

    function automatic logic fmt_is_4dw(logic [2:0] fmt);
        return fmt inside {TLP_4DW_ND, TLP_4DW_WD};
    endfunction

    function automatic logic fmt_has_data(logic [2:0] fmt);
        return fmt inside {TLP_3DW_WD, TLP_4DW_WD};
    endfunction

    // Length field of 0 encodes the maximum of 1024 dwords
    function automatic logic [10:0] len_dwords(logic [9:0] length);
        return (length == 10'd0) ? 11'd1024 : {1'b0, length};
    endfunction

endpackage

// File: rtl/axis_to_pcie_converter.sv
// Rebuilds 128b segmented TLP beats from a 32-bit AXIS dword stream.
// Define AXIS_TO_PCIE_LEN_CHECK_EN to check payload count against the Length field.
module axis_to_pcie_converter
    import pcie_tlp_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int USER_WIDTH     = 1,
    parameter int TLP_SEG_COUNT  = 1,
    parameter int TLP_DATA_WIDTH = 128,
    parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 32,
    parameter int TLP_HDR_WIDTH  = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    input  logic [USER_WIDTH-1:0]        s_axis_tuser,
    output logic                         s_axis_tready,
    output logic [TLP_DATA_WIDTH-1:0]    rx_tlp_data,
    output logic [TLP_STRB_WIDTH-1:0]    rx_tlp_strb,
    output logic [TLP_HDR_WIDTH-1:0]     rx_tlp_hdr,
    output logic [TLP_SEG_COUNT*4-1:0]   rx_tlp_error,
    output logic [TLP_SEG_COUNT-1:0]     rx_tlp_valid,
    output logic [TLP_SEG_COUNT-1:0]     rx_tlp_sop,
    output logic [TLP_SEG_COUNT-1:0]     rx_tlp_eop,
    input  logic                         rx_tlp_ready
);

    if (DATA_WIDTH != 32 || TLP_SEG_COUNT != 1 || TLP_DATA_WIDTH != 128) begin : g_bad_cfg
        $error("axis_to_pcie_converter: only 32b AXIS, 1 segment, 128b beats supported");
    end

`ifdef AXIS_TO_PCIE_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_EMIT, ST_DROP} state_e;

    typedef struct packed {
        state_e           state;
        logic [1:0]       hdr_cnt;
        logic [10:0]      pay_cnt;
        logic             first;
        logic             err;
        tlp_hdr_union_t   hdr;
        logic [3:0][31:0] acc;
        logic [3:0]       acc_strb;
        logic             out_valid;
        logic             out_sop;
        logic             out_eop;
        logic [3:0]       out_strb;
        logic [3:0]       out_err;
        logic [3:0][31:0] out_data;
        logic [127:0]     out_hdr;
    } fsm_t;

    fsm_t        q, d;
    tlp_dw0_t    dw0;
    logic        ready, xfer, last_hdr, len_hit, len_err, end_tlp;
    logic [1:0]  lane;
    logic [10:0] cnt_n;
    logic [31:0] swapped;
    logic        unused_bits;

    function automatic fsm_t load_beat(fsm_t s, logic [3:0][31:0] data, logic [3:0] strb,
                                       logic [127:0] hdr, logic sop, logic eop, logic [3:0] err);
        fsm_t r = s;
        r.out_valid = 1'b1;
        r.out_data  = data;
        r.out_strb  = strb;
        r.out_hdr   = hdr;
        r.out_sop   = sop;
        r.out_eop   = eop;
        r.out_err   = err;
        return r;
    endfunction

    assign dw0     = tlp_dw0_t'(q.hdr.dw[3]);
    assign swapped = {s_axis_tdata[7:0], s_axis_tdata[15:8], s_axis_tdata[23:16], s_axis_tdata[31:24]};
    // Dropping never touches the beat register, so it may proceed while a beat is held
    assign ready   = !rst_i && (q.state == ST_DROP ||
                     (q.state != ST_EMIT && !(q.out_valid && !rx_tlp_ready)));
    assign xfer    = s_axis_tvalid && ready;
    assign lane    = q.pay_cnt[1:0];
    assign cnt_n   = (q.pay_cnt == 11'd1024) ? q.pay_cnt : q.pay_cnt + 11'd1;
    assign len_hit = LEN_CHECK && (cnt_n == len_dwords(dw0.length));
    assign end_tlp = s_axis_tlast || len_hit;
    assign len_err = LEN_CHECK && (s_axis_tlast != len_hit);
    assign last_hdr = q.hdr_cnt == (fmt_is_4dw(dw0.fmt) ? 2'd3 : 2'd2);
    assign unused_bits = ^{s_axis_tkeep, dw0};

    always_comb begin
        d = q;
        if (q.out_valid && rx_tlp_ready) begin
            d.out_valid = 1'b0;
            d.out_sop   = 1'b0;
            d.out_eop   = 1'b0;
        end
        case (q.state)
            ST_IDLE: if (xfer && !s_axis_tlast) begin
                d.hdr.raw = {s_axis_tdata[31:0], 96'd0};
                d.hdr_cnt = 2'd1;
                d.err     = s_axis_tuser[0];
                d.state   = ST_HDR;
            end
            ST_HDR: if (xfer) begin
                d.hdr.dw[~q.hdr_cnt] = s_axis_tdata[31:0];
                d.err     = q.err | s_axis_tuser[0];
                d.hdr_cnt = q.hdr_cnt + 2'd1;
                if (!last_hdr) begin
                    if (s_axis_tlast)
                        d.state = ST_IDLE;
                end else if (!fmt_has_data(dw0.fmt) || s_axis_tlast) begin
                    d = load_beat(d, '0, 4'b0, d.hdr.raw, 1'b1, 1'b1,
                                  {2'b00, d.err, LEN_CHECK && fmt_has_data(dw0.fmt)});
                    d.state = s_axis_tlast ? ST_EMIT : ST_DROP;
                end else begin
                    d.state    = ST_PAYLOAD;
                    d.pay_cnt  = '0;
                    d.acc      = '0;
                    d.acc_strb = '0;
                    d.first    = 1'b1;
                end
            end
            ST_PAYLOAD: if (xfer) begin
                d.acc[~lane]      = swapped;
                d.acc_strb[~lane] = 1'b1;
                d.pay_cnt         = cnt_n;
                d.err             = q.err | s_axis_tuser[0];
                if (lane == 2'd3 || end_tlp) begin
                    d = load_beat(d, d.acc, d.acc_strb, q.first ? q.hdr.raw : '0, q.first,
                                  end_tlp, end_tlp ? {2'b00, d.err, len_err} : 4'b0);
                    d.first    = 1'b0;
                    d.acc      = '0;
                    d.acc_strb = '0;
                    if (end_tlp)
                        d.state = s_axis_tlast ? ST_EMIT : ST_DROP;
                end
            end
            // Final beat must leave the register before the next TLP's DW0 is taken
            ST_EMIT: if (!q.out_valid || rx_tlp_ready) d.state = ST_IDLE;
            ST_DROP: if (xfer && s_axis_tlast) d.state = ST_IDLE;
            default: d.state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) q <= '0;
        else       q <= d;
    end

    assign s_axis_tready = ready;
    assign rx_tlp_data   = q.out_data;
    assign rx_tlp_strb   = q.out_strb;
    assign rx_tlp_hdr    = q.out_hdr;
    assign rx_tlp_error  = q.out_err;
    assign rx_tlp_valid  = q.out_valid;
    assign rx_tlp_sop    = q.out_sop;
    assign rx_tlp_eop    = q.out_eop;

endmodule
